zdraw_scheduler: RTL



---
 rtl/zdraw_scheduler.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/zdraw_scheduler.sv
// zdraw_scheduler: runs the init draw slots once, then loops over the masked periodic slots.
// Optional done-handshake watchdog with sticky oWdt_Err: define ZDRAW_SCHED_WDT_EN.

module zdraw_scheduler #(
  parameter int NUM_SLOTS  = 8,
  parameter int INIT_SLOTS = 3,
  parameter int CMD_W      = 4,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 2
`ifdef ZDRAW_SCHED_WDT_EN
  ,
  parameter int WDT_CYCLES = 1000000
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_SLOTS*CMD_W-1:0]  iSlot_Cmd,
  input  logic [NUM_SLOTS*DATA_W-1:0] iSlot_Data,
  input  logic [NUM_SLOTS-1:0]        iSlot_Mask,
  input  logic [NUM_SLOTS-1:0]        iUpdate_Req,
  output logic                        oCore_En,
  output logic [CMD_W-1:0]            oCore_Cmd,
  output logic [DATA_W-1:0]           oCore_Data,
  input  logic                        iCore_Done,
  output logic                        oInit_Done,
  output logic                        oFrame_Tick,
  output logic                        oBusy,
  output logic [NUM_SLOTS-1:0]        oPending
`ifdef ZDRAW_SCHED_WDT_EN
  ,
  output logic                        oWdt_Err
`endif
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(NUM_SLOTS - 1);
  localparam logic [PTR_W-1:0] FIRST_LOOP = PTR_W'(INIT_SLOTS);
  localparam logic [PTR_W-1:0] LAST_INIT  = PTR_W'(INIT_SLOTS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [NUM_SLOTS-1:0] LOOP_MASK = {NUM_SLOTS{1'b1}} << INIT_SLOTS;
  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_PRIME,
    S_SELECT,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_GAP
  } state_t;

  state_t               state, state_next;
  logic [PTR_W-1:0]     ptr, ptr_next;
  logic [PTR_W-1:0]     cur_slot, cur_slot_next;
  logic                 cur_scan, cur_scan_next;
  logic [7:0]           gap_cnt, gap_next;
  logic                 init_next;
  logic                 tick_next;
  logic                 load;
  logic                 wrap;
  logic [NUM_SLOTS-1:0] clr;
  logic [NUM_SLOTS-1:0] pending_next;
  logic                 pend_any;
  logic [PTR_W-1:0]     pend_slot;

`ifdef ZDRAW_SCHED_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] wdt_cnt, wdt_cnt_next;
  logic             wdt_err_next;
`endif

  assign oBusy = oCore_En;

  // Lowest-index pending loop slot; init slots can never be pending.
  always_comb begin
    pend_any  = 1'b0;
    pend_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= INIT_SLOTS; i--) begin
      if (oPending[i]) begin
        pend_any  = 1'b1;
        pend_slot = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    cur_slot_next = cur_slot;
    cur_scan_next = cur_scan;
    gap_next      = gap_cnt;
    init_next     = oInit_Done;
    tick_next     = 1'b0;
    load          = 1'b0;
    wrap          = 1'b0;
    clr           = '0;
`ifdef ZDRAW_SCHED_WDT_EN
    wdt_cnt_next  = wdt_cnt;
    wdt_err_next  = oWdt_Err;
`endif

    unique case (state)
      S_PRIME: state_next = S_SELECT;

      S_SELECT: begin
        if (!oInit_Done) begin
          load          = 1'b1;
          cur_slot_next = ptr;
          cur_scan_next = 1'b1;
          state_next    = S_ISSUE;
        end else if (en) begin
          if (pend_any) begin
            load          = 1'b1;
            cur_slot_next = pend_slot;
            cur_scan_next = 1'b0;
            state_next    = S_ISSUE;
          end else if (!iSlot_Mask[ptr]) begin
            if (ptr == LAST_SLOT) wrap = 1'b1;
            else ptr_next = ptr + PTR_ONE;
          end else begin
            load          = 1'b1;
            cur_slot_next = ptr;
            cur_scan_next = 1'b1;
            state_next    = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        clr[cur_slot] = 1'b1;
`ifdef ZDRAW_SCHED_WDT_EN
        wdt_cnt_next  = '0;
`endif
        state_next    = iCore_Done ? S_RELEASE : S_WAIT;
      end

      S_WAIT: begin
`ifdef ZDRAW_SCHED_WDT_EN
        if (iCore_Done) begin
          state_next = S_RELEASE;
        end else if (wdt_cnt == WDT_LAST) begin
          state_next   = S_RELEASE;
          wdt_err_next = 1'b1;
        end else begin
          wdt_cnt_next = wdt_cnt + WDT_W'(1);
        end
`else
        if (iCore_Done) state_next = S_RELEASE;
`endif
      end

      // Only scan-issued slots move the pointer; pending redraws leave it alone.
      S_RELEASE: begin
        state_next = S_SELECT;
        if (!oInit_Done) begin
          if (ptr == LAST_INIT) begin
            init_next = 1'b1;
            ptr_next  = FIRST_LOOP;
          end else begin
            ptr_next = ptr + PTR_ONE;
          end
        end else if (cur_scan) begin
          if (ptr == LAST_SLOT) wrap = 1'b1;
          else ptr_next = ptr + PTR_ONE;
        end
      end

      S_GAP: begin
        if (gap_cnt == 8'd0) state_next = S_SELECT;
        else gap_next = gap_cnt - 8'd1;
      end

      default: state_next = S_PRIME;
    endcase

    if (wrap) begin
      tick_next = 1'b1;
      ptr_next  = FIRST_LOOP;
      if (GAP_CYCLES == 0) begin
        state_next = S_SELECT;
      end else begin
        state_next = S_GAP;
        gap_next   = GAP_LOAD;
      end
    end

    // A request arriving with the clear must survive, so the set is applied last.
    pending_next = (oPending & ~clr) | (iUpdate_Req & LOOP_MASK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_PRIME;
      ptr         <= '0;
      cur_slot    <= '0;
      cur_scan    <= 1'b0;
      gap_cnt     <= '0;
      oCore_En    <= 1'b0;
      oCore_Cmd   <= '0;
      oCore_Data  <= '0;
      oInit_Done  <= 1'b0;
      oFrame_Tick <= 1'b0;
      oPending    <= '0;
`ifdef ZDRAW_SCHED_WDT_EN
      wdt_cnt     <= '0;
      oWdt_Err    <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cur_slot    <= cur_slot_next;
      cur_scan    <= cur_scan_next;
      gap_cnt     <= gap_next;
      oCore_En    <= (state_next == S_ISSUE) || (state_next == S_WAIT);
      oInit_Done  <= init_next;
      oFrame_Tick <= tick_next;
      oPending    <= pending_next;
`ifdef ZDRAW_SCHED_WDT_EN
      wdt_cnt     <= wdt_cnt_next;
      oWdt_Err    <= wdt_err_next;
`endif
      if (load) begin
        oCore_Cmd  <= iSlot_Cmd[cur_slot_next*CMD_W +: CMD_W];
        oCore_Data <= iSlot_Data[cur_slot_next*DATA_W +: DATA_W];
      end
    end
  end

endmodule
